sandpiper_7seg_bus_monitor: RTL and testbench
=============================================

# sandpiper_7seg_bus_monitor

Passive receiver for the Sandpiper 7-segment serial bus (SCLK/DOUT/RCLK/~OE into two cascaded 74HCS596). It models the 16-bit shift/storage register pair in the sys_clk domain. On each latch it decodes the common-anode byte into a character index and keeps a readable shadow of all displayed segment patterns. It also measures ~OE on-time and flags malformed frames. Used in loopback self-test builds and as the bench scoreboard front end for the display driver.

## Interface
- SEG_CT, 8, segment bits per frame (DP,G,F,E,D,C,B,A in [7:0]); fixed at 8
- CAN_CT, 8, common-anode bits per frame; fixed at 8, power of 2
- SYNC_STAGES, 2, synchronizer flops per bus input (>=2)
- PWM_WINDOW, 512, sys_clk cycles per ~OE measurement window (power of 2)
- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bus_sclk  in  1  shift clock pin; shift on rising edge
- bus_dout  in  1  serial data pin
- bus_rclk  in  1  storage latch pin; latch on rising edge
- bus_oe_n  in  1  output enable pin, active low
- rd_idx  in  $clog2(CAN_CT)  shadow readback index
- rd_seg  out  SEG_CT  registered shadow segments for rd_idx
- frame_valid  out  1  one-cycle pulse: well-formed frame latched
- frame_idx  out  $clog2(CAN_CT)  char index of last valid frame
- frame_seg  out  SEG_CT  segments of last valid frame
- len_err  out  1  one-cycle pulse: latch after bit count != 16
- anode_err  out  1  one-cycle pulse: anode byte not one-hot and not zero
- err_ct  out  8  saturating count of len_err + anode_err events
- oe_on_ct  out  $clog2(PWM_WINDOW)+1  ~OE-low cycles in last completed window

## Operation
- Each bus input passes through SYNC_STAGES flops, then one edge-detect flop. A rising edge is detected when the previous synchronized value is 0 and the current value is 1.
- Shift register sr[15:0]: on SCLK rise, sr <= {dout_sync, sr[15:1]}. The driver sends LSB first, so after 16 shifts sr = {CA[7:0], SEG[7:0]}.
- bit_ct (5 bits) increments on each SCLK rise and saturates at 31. It clears on RCLK rise.
- On RCLK rise, evaluate the pre-shift contents of sr and the pre-increment bit_ct:
  - If bit_ct != 16: pulse len_err. No shadow write, frame_* unchanged.
  - Else if CA == 0: blank frame. No pulses, no write.
  - Else if CA is one-hot: idx = bit position of CA. Write shadow[idx] <= SEG, load frame_idx/frame_seg, pulse frame_valid.
  - Else: pulse anode_err. No write.
- len_err takes priority over anode_err. At most one error pulse per latch.
- err_ct increments by 1 per error pulse and saturates at 255.
- SCLK rise and RCLK rise in the same cycle: the latch uses the pre-shift sr and bit_ct. The shift still happens, and bit_ct becomes 1, counting toward the next frame.
- Shadow memory: CAN_CT x SEG_CT, initialised to 0 by reset. rd_seg <= shadow[rd_idx] every cycle.
- A write and a read to the same index in the same cycle: rd_seg shows the old value, and the new value appears the next cycle.
- ~OE measurement:
  - win_ct counts 0..PWM_WINDOW-1 and wraps.
  - acc counts cycles where the synchronized oe_n == 0.
  - At win_ct == PWM_WINDOW-1: oe_on_ct <= acc + (oe_n==0), and acc clears.

## Timing
- Reset values: all outputs 0, shadow 0, sr 0, bit_ct 0, win_ct 0, acc 0, synchronizers 0.
- Any event from a pin transition to its response: SYNC_STAGES+2 sys_clk rising edges. With the default of 2, a bus_rclk rise sampled at edge k gives frame_valid/len_err/anode_err high during the cycle after edge k+3, for exactly one cycle.
- frame_idx and frame_seg update in the same cycle frame_valid rises.
- rd_seg latency: 1 cycle after rd_idx, plus 1 cycle after a shadow write.
- oe_on_ct updates once per PWM_WINDOW cycles, on the wrap cycle. Range is 0..PWM_WINDOW.
- Minimum resolvable bus pulse width is 2 sys_clk cycles high and 2 low. Shorter pulses may be missed, and no error is guaranteed for them.
- rst mid-frame: the partial frame is discarded. The next frame needs 16 fresh SCLK rises before RCLK.

## Test plan
- Shift 16 bits of 0x04_3F (CA=0x04, SEG=0x3F), LSB first, then pulse RCLK -> one frame_valid pulse, frame_idx=2, frame_seg=0x3F. Then rd_idx=2 -> rd_seg=0x3F.
- Drive eight frames CA=0x01..0x80 with SEG=idx+1, then read rd_idx 0..7 -> 0x01..0x08. err_ct=0.
- 15 SCLKs then RCLK -> len_err pulse, shadow unchanged, err_ct=1. 17 SCLKs then RCLK -> second len_err, err_ct=2.
- Frame CA=0x05 -> anode_err, no write. CA=0x00 -> no pulses, no write. 260 bad frames -> err_ct saturates at 255.
- Hold bus_oe_n low for 128 of every 512 cycles, aligned to the window -> oe_on_ct=128. Hold low continuously -> 512. Hold high -> 0.
- Assert rst after 8 of 16 bits, then send a full 16-bit CA=0x10 frame -> frame_valid, frame_idx=4, no len_err. A 16th SCLK coinciding with RCLK -> len_err (15 counted).

Source files
------------

// File: rtl/sandpiper_7seg_bus_monitor.sv
// Passive receiver for the Sandpiper 7-segment serial bus (two cascaded 74HCS596).
// Rebuilds latched frames in the sys_clk domain, shadows segment patterns and measures ~OE duty.
module sandpiper_7seg_bus_monitor #(
    parameter int SEG_CT      = 8,
    parameter int CAN_CT      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PWM_WINDOW  = 512
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          bus_sclk,
    input  logic                          bus_dout,
    input  logic                          bus_rclk,
    input  logic                          bus_oe_n,
    input  logic [$clog2(CAN_CT)-1:0]     rd_idx,
    output logic [SEG_CT-1:0]             rd_seg,
    output logic                          frame_valid,
    output logic [$clog2(CAN_CT)-1:0]     frame_idx,
    output logic [SEG_CT-1:0]             frame_seg,
    output logic                          len_err,
    output logic                          anode_err,
    output logic [7:0]                    err_ct,
    output logic [$clog2(PWM_WINDOW):0]   oe_on_ct
);

    localparam int IDX_W      = $clog2(CAN_CT);
    localparam int WIN_W      = $clog2(PWM_WINDOW);
    localparam int OE_W       = WIN_W + 1;
    localparam int FRAME_BITS = SEG_CT + CAN_CT;

    logic [SYNC_STAGES-1:0] sclk_sync, dout_sync, rclk_sync, oe_sync;
    logic                   sclk_prev, rclk_prev;
    logic                   sclk_rise, rclk_rise;
    logic                   dout_d, oe_n_d;

    logic [FRAME_BITS-1:0]  sr;
    logic [4:0]             bit_ct;
    logic [CAN_CT-1:0]      ca;
    logic [SEG_CT-1:0]      seg;
    logic                   ca_onehot;
    logic [IDX_W-1:0]       ca_idx;
    logic                   latch_len_bad, latch_anode_bad, latch_good;

    logic [SEG_CT-1:0]      shadow [CAN_CT];

    logic [WIN_W-1:0]       win_ct;
    logic [OE_W-1:0]        acc;
    logic                   oe_on;

    // Edge pulses are registered so every pin event reaches the outputs SYNC_STAGES+2 edges later;
    // dout and oe_n are delayed one extra flop to stay aligned with the detected edges.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_sync <= '0;
            dout_sync <= '0;
            rclk_sync <= '0;
            oe_sync   <= '0;
            sclk_prev <= 1'b0;
            rclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            rclk_rise <= 1'b0;
            dout_d    <= 1'b0;
            oe_n_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus_sclk};
            dout_sync <= {dout_sync[SYNC_STAGES-2:0], bus_dout};
            rclk_sync <= {rclk_sync[SYNC_STAGES-2:0], bus_rclk};
            oe_sync   <= {oe_sync[SYNC_STAGES-2:0], bus_oe_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            rclk_prev <= rclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            rclk_rise <= rclk_sync[SYNC_STAGES-1] & ~rclk_prev;
            dout_d    <= dout_sync[SYNC_STAGES-1];
            oe_n_d    <= oe_sync[SYNC_STAGES-1];
        end
    end

    assign ca        = sr[FRAME_BITS-1:SEG_CT];
    assign seg       = sr[SEG_CT-1:0];
    assign ca_onehot = (ca != '0) && ((ca & (ca - CAN_CT'(1))) == '0);

    always_comb begin
        ca_idx = '0;
        for (int i = 0; i < CAN_CT; i++) begin
            if (ca[i]) ca_idx = IDX_W'(i);
        end
    end

    // Latch decisions use the pre-shift register and pre-increment count.
    assign latch_len_bad   = rclk_rise && (bit_ct != 5'(FRAME_BITS));
    assign latch_good      = rclk_rise && (bit_ct == 5'(FRAME_BITS)) && ca_onehot;
    assign latch_anode_bad = rclk_rise && (bit_ct == 5'(FRAME_BITS)) && !ca_onehot && (ca != '0);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sr          <= '0;
            bit_ct      <= '0;
            frame_valid <= 1'b0;
            frame_idx   <= '0;
            frame_seg   <= '0;
            len_err     <= 1'b0;
            anode_err   <= 1'b0;
            err_ct      <= '0;
        end else begin
            frame_valid <= latch_good;
            len_err     <= latch_len_bad;
            anode_err   <= latch_anode_bad;
            if (sclk_rise) sr <= {dout_d, sr[FRAME_BITS-1:1]};
            if (rclk_rise) bit_ct <= sclk_rise ? 5'd1 : 5'd0;
            else if (sclk_rise && bit_ct != 5'd31) bit_ct <= bit_ct + 5'd1;
            if (latch_good) begin
                frame_idx <= ca_idx;
                frame_seg <= seg;
            end
            if ((latch_len_bad || latch_anode_bad) && err_ct != 8'd255) err_ct <= err_ct + 8'd1;
        end
    end

    // Readback sees the pre-write value when a write hits the same index in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < CAN_CT; i++) shadow[i] <= '0;
            rd_seg <= '0;
        end else begin
            if (latch_good) shadow[ca_idx] <= seg;
            rd_seg <= shadow[rd_idx];
        end
    end

    assign oe_on = ~oe_n_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            win_ct   <= '0;
            acc      <= '0;
            oe_on_ct <= '0;
        end else begin
            win_ct <= win_ct + WIN_W'(1);
            if (win_ct == WIN_W'(PWM_WINDOW - 1)) begin
                oe_on_ct <= acc + OE_W'(oe_on);
                acc      <= '0;
            end else begin
                acc <= acc + OE_W'(oe_on);
            end
        end
    end

endmodule

// File: tb/tb_sandpiper_7seg_bus_monitor.sv
// Scoreboard bench: bus driver tasks feed a frame-level reference model whose expected
// pulses are queued and popped by an independent monitor on the falling clock edge.
module tb_sandpiper_7seg_bus_monitor;

    localparam int SEG_CT      = 8;
    localparam int CAN_CT      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int PWM_WINDOW  = 512;
    localparam int IDX_W       = $clog2(CAN_CT);
    localparam int OE_W        = $clog2(PWM_WINDOW) + 1;

    logic               sys_clk = 1'b0;
    logic               rst = 1'b1;
    logic               bus_sclk = 1'b0;
    logic               bus_dout = 1'b0;
    logic               bus_rclk = 1'b0;
    logic               bus_oe_n = 1'b1;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic [SEG_CT-1:0]  rd_seg;
    logic               frame_valid;
    logic [IDX_W-1:0]   frame_idx;
    logic [SEG_CT-1:0]  frame_seg;
    logic               len_err;
    logic               anode_err;
    logic [7:0]         err_ct;
    logic [OE_W-1:0]    oe_on_ct;

    sandpiper_7seg_bus_monitor #(
        .SEG_CT(SEG_CT), .CAN_CT(CAN_CT), .SYNC_STAGES(SYNC_STAGES), .PWM_WINDOW(PWM_WINDOW)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .bus_sclk(bus_sclk), .bus_dout(bus_dout), .bus_rclk(bus_rclk), .bus_oe_n(bus_oe_n),
        .rd_idx(rd_idx), .rd_seg(rd_seg),
        .frame_valid(frame_valid), .frame_idx(frame_idx), .frame_seg(frame_seg),
        .len_err(len_err), .anode_err(anode_err), .err_ct(err_ct), .oe_on_ct(oe_on_ct)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum int {EV_FRAME, EV_LEN, EV_ANODE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       idx;
        int       seg;
    } ev_t;

    ev_t  exp_q[$];
    bit   bits_q[$];
    int   model_shadow[CAN_CT];
    int   model_err = 0;
    int   model_idx = 0;
    int   model_seg = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   oe_mode = 0;
    int   oe_phase = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic model_reset();
        bits_q.delete();
        for (int i = 0; i < CAN_CT; i++) model_shadow[i] = 0;
        model_err = 0;
        model_idx = 0;
        model_seg = 0;
    endtask

    task automatic model_push(input ev_kind_e kind);
        ev_t e;
        e.kind = kind;
        e.idx  = model_idx;
        e.seg  = model_seg;
        exp_q.push_back(e);
    endtask

    // Frame-level rules: exact 16-bit count, then blank / one-hot / malformed anode byte.
    task automatic model_latch();
        logic [15:0] word;
        int ca;
        if (bits_q.size() != 16) begin
            if (model_err < 255) model_err++;
            model_push(EV_LEN);
        end else begin
            for (int i = 0; i < 16; i++) word[i] = bits_q[i];
            ca = int'(word[15:8]);
            if (ca == 0) begin
            end else if ($countones(ca) == 1) begin
                model_idx = $clog2(ca);
                model_seg = int'(word[7:0]);
                model_shadow[model_idx] = model_seg;
                model_push(EV_FRAME);
            end else begin
                if (model_err < 255) model_err++;
                model_push(EV_ANODE);
            end
        end
        bits_q.delete();
    endtask

    task automatic shift_bit(input bit b);
        bus_dout = b;
        wait_cycles(2);
        bus_sclk = 1'b1;
        bits_q.push_back(b);
        wait_cycles(2);
        bus_sclk = 1'b0;
    endtask

    task automatic pulse_latch();
        bus_rclk = 1'b1;
        model_latch();
        wait_cycles(2);
        bus_rclk = 1'b0;
        wait_cycles(2);
    endtask

    task automatic apply_stimulus(input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) shift_bit(i < 16 ? word[i] : 1'($urandom));
        pulse_latch();
    endtask

    task automatic drain_and_check(input string tag);
        wait_cycles(10);
        check_output({tag, " pending events"}, exp_q.size(), 0);
        check_output({tag, " err_ct"}, err_ct, model_err);
    endtask

    task automatic check_shadow(input string tag);
        for (int i = 0; i < CAN_CT; i++) begin
            rd_idx = IDX_W'(i);
            wait_cycles(2);
            check_output($sformatf("%s rd_seg[%0d]", tag, i), rd_seg, model_shadow[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_sclk = 1'b0;
        bus_rclk = 1'b0;
        bus_dout = 1'b0;
        model_reset();
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
    endtask

    // ~OE generator: mode 0 high, mode 1 low, mode 2 low for 128 of every 512 cycles.
    always @(negedge sys_clk) begin
        oe_phase = (oe_phase + 1) % PWM_WINDOW;
        case (oe_mode)
            1:       bus_oe_n = 1'b0;
            2:       bus_oe_n = (oe_phase < 128) ? 1'b0 : 1'b1;
            default: bus_oe_n = 1'b1;
        endcase
    end

    always @(negedge sys_clk) begin
        ev_t e;
        if (!rst && (frame_valid || len_err || anode_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected pulse: got fv=%0b le=%0b ae=%0b, expected none",
                         frame_valid, len_err, anode_err);
            end else begin
                e = exp_q.pop_front();
                check_output("frame_valid", frame_valid, int'(e.kind == EV_FRAME));
                check_output("len_err", len_err, int'(e.kind == EV_LEN));
                check_output("anode_err", anode_err, int'(e.kind == EV_ANODE));
                check_output("frame_idx", frame_idx, e.idx);
                check_output("frame_seg", frame_seg, e.seg);
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  ca;
        int          nb;

        model_reset();
        wait_cycles(4);
        rst = 1'b0;
        check_output("reset rd_seg", rd_seg, 0);
        check_output("reset frame_valid", frame_valid, 0);
        check_output("reset frame_idx", frame_idx, 0);
        check_output("reset frame_seg", frame_seg, 0);
        check_output("reset len_err", len_err, 0);
        check_output("reset anode_err", anode_err, 0);
        check_output("reset err_ct", err_ct, 0);
        check_output("reset oe_on_ct", oe_on_ct, 0);

        apply_stimulus(16'h043F, 16);
        drain_and_check("first frame");
        rd_idx = 3'd2;
        wait_cycles(2);
        check_output("rd_seg idx2", rd_seg, 'h3F);

        for (int i = 0; i < CAN_CT; i++) apply_stimulus({8'(1 << i), 8'(i + 1)}, 16);
        drain_and_check("eight frames");
        check_shadow("eight frames");

        apply_stimulus(16'h08AA, 15);
        drain_and_check("15 bits");
        apply_stimulus(16'h08AA, 17);
        drain_and_check("17 bits");
        check_shadow("after len errors");

        apply_stimulus(16'h0555, 16);
        apply_stimulus(16'h0066, 16);
        drain_and_check("anode and blank");
        check_shadow("after anode and blank");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                1:       ca = 8'h00;
                2:       ca = 8'($urandom);
                default: ca = 8'(1 << $urandom_range(0, 7));
            endcase
            w  = {ca, 8'($urandom)};
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 18) : 16;
            apply_stimulus(w, nb);
        end
        drain_and_check("random frames");
        check_shadow("random frames");

        for (int n = 0; n < 260; n++) pulse_latch();
        drain_and_check("saturation");
        check_output("err_ct saturated", err_ct, 255);

        oe_mode = 2;
        wait_cycles(3 * PWM_WINDOW);
        check_output("oe_on_ct pwm", oe_on_ct, 128);
        oe_mode = 1;
        wait_cycles(3 * PWM_WINDOW);
        check_output("oe_on_ct low", oe_on_ct, 512);
        oe_mode = 0;
        wait_cycles(3 * PWM_WINDOW);
        check_output("oe_on_ct high", oe_on_ct, 0);

        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        do_reset();
        check_output("mid reset err_ct", err_ct, 0);
        apply_stimulus(16'h1077, 16);
        drain_and_check("after mid reset");
        check_shadow("after mid reset");

        w = 16'h2011;
        for (int i = 0; i < 15; i++) shift_bit(w[i]);
        bus_dout = w[15];
        wait_cycles(2);
        bus_sclk = 1'b1;
        bus_rclk = 1'b1;
        model_latch();
        bits_q.push_back(w[15]);
        wait_cycles(2);
        bus_sclk = 1'b0;
        bus_rclk = 1'b0;
        wait_cycles(2);
        drain_and_check("coincident latch");
        check_shadow("coincident latch");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
